// File: rtl/video_pkg.sv
// video_pkg: shared mode/state types and colour-bar constants for the pattern source
package video_pkg;
  typedef enum logic [1:0] {MODE_RAMP, MODE_CHECKER, MODE_BARS, MODE_CONST} mode_t;
  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F, 16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };
endpackage

// File: rtl/video_timing_ctr.sv
// video_timing_ctr: pixel/line counters and the line-granular frame state machine
module video_timing_ctr
  import video_pkg::*;
#(
  parameter int H_ACT       = 640,
  parameter int H_BLANK     = 160,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 2,
  parameter int V_ACT       = 480,
  parameter int V_FRONT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] hcnt,
  output logic [15:0] vcnt,
  output logic        line_end,
  output logic        frame_end,
  output logic        frame_start,
  output logic        idle,
  output logic        vsync_line,
  output logic        active_line,
  output logic        active
);
  localparam int LT = H_ACT + H_BLANK;
  localparam state_t AFTER_ACTIVE = V_FRONT > 0 ? VFRONT : IDLE;
  localparam state_t AFTER_VBACK  = V_ACT > 0 ? ACTIVE : AFTER_ACTIVE;
  localparam state_t AFTER_VSYNC  = V_BACK > 0 ? VBACK : AFTER_VBACK;
  localparam state_t LAST = V_FRONT > 0 ? VFRONT : V_ACT > 0 ? ACTIVE : V_BACK > 0 ? VBACK : VSYNC;
  state_t state, nxt;
  logic [15:0] lines;
  logic last_line;
  // decode the current position; empty states are skipped via the AFTER_* chain
  always_comb begin
    idle        = state == IDLE;
    vsync_line  = state == VSYNC;
    active_line = state == ACTIVE;
    active      = active_line && hcnt < 16'(H_ACT);
    lines       = state == VSYNC ? 16'(VSYNC_LINES) : state == VBACK ? 16'(V_BACK) :
                  state == ACTIVE ? 16'(V_ACT) : 16'(V_FRONT);
    last_line   = vcnt == lines - 16'd1;
    line_end    = !idle && hcnt == 16'(LT - 1);
    frame_end   = line_end && last_line && state == LAST;
    frame_start = en && (idle || frame_end);
    nxt         = state == LAST ? (en ? VSYNC : IDLE) : state == VSYNC ? AFTER_VSYNC :
                  state == VBACK ? AFTER_VBACK : AFTER_ACTIVE;
  end
  // advance pixel and line counters, stepping the state machine at the last line of each state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hcnt  <= '0;
      vcnt  <= '0;
    end else if (idle) begin
      if (en) state <= VSYNC;
    end else if (line_end) begin
      hcnt <= '0;
      vcnt <= last_line ? '0 : vcnt + 16'd1;
      if (last_line) state <= nxt;
    end else begin
      hcnt <= hcnt + 16'd1;
    end
  end
endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source: CMOS-style vsync/href/data source with selectable test patterns
module video_pattern_source
  import video_pkg::*;
#(
  parameter int   IMG_HDISP   = 640,
  parameter int   IMG_VDISP   = 480,
  parameter int   H_BLANK     = 160,
  parameter int   VSYNC_LINES = 3,
  parameter int   V_BACK      = 2,
  parameter int   V_FRONT     = 2,
  parameter logic VSYNC_VALID = 1'b1,
  parameter int   DATA_W      = 8,
  parameter int   FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [15:0]            const_val,
  output logic                   vsync,
  output logic                   href,
  output logic [DATA_W-1:0]      data,
  output logic                   clken,
  output logic [15:0]            pix_x,
  output logic [15:0]            pix_y,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   frame_done,
  output logic                   busy
);
  localparam int BPP   = 16 / DATA_W;
  localparam int BAR_W = IMG_HDISP / 8;
  logic [15:0] hcnt, vcnt, x, px, const_q, bar_px;
  logic [2:0] bar_idx;
  logic line_end, frame_end, frame_start, idle, vsync_line, active_line, active, last_byte;
  mode_t mode_q;
  video_timing_ctr #(
    .H_ACT(IMG_HDISP * BPP), .H_BLANK(H_BLANK), .VSYNC_LINES(VSYNC_LINES),
    .V_BACK(V_BACK), .V_ACT(IMG_VDISP), .V_FRONT(V_FRONT)
  ) u_ctr (
    .clk(clk), .rst(rst), .en(en), .hcnt(hcnt), .vcnt(vcnt), .line_end(line_end),
    .frame_end(frame_end), .frame_start(frame_start), .idle(idle),
    .vsync_line(vsync_line), .active_line(active_line), .active(active)
  );
  // pixel column and the RGB565 value for the current position
  always_comb begin
    x         = hcnt >> (BPP - 1);
    last_byte = BPP == 1 || hcnt[0];
    px        = mode_q == MODE_RAMP ? x + vcnt + 16'(frame_cnt) :
                mode_q == MODE_CHECKER ? {16{x[3] ^ vcnt[3]}} :
                mode_q == MODE_BARS ? BAR_RGB[bar_idx] : const_q;
  end
  // pattern selection is frozen for a whole frame, captured as the frame starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_RAMP;
      const_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode_t'(mode);
      const_q <= const_val;
    end
  end
  // bar-width counter walks the eight colour bars along the active line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (line_end) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (active && last_byte) begin
      bar_px <= bar_px == 16'(BAR_W - 1) ? '0 : bar_px + 16'd1;
      if (bar_px == 16'(BAR_W - 1)) bar_idx <= bar_idx + 3'd1;
    end
  end
  // registered outputs; the high byte goes out on the even cycle of each pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync      <= ~VSYNC_VALID;
      href       <= 1'b0;
      clken      <= 1'b0;
      data       <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      vsync      <= vsync_line ? VSYNC_VALID : ~VSYNC_VALID;
      href       <= active;
      clken      <= active;
      data       <= active ? DATA_W'(BPP == 2 && !hcnt[0] ? px >> 8 : px) : '0;
      pix_x      <= active ? x : '0;
      pix_y      <= active_line ? vcnt : vsync_line ? '0 : pix_y;
      frame_cnt  <= frame_cnt + FRAME_CNT_W'(frame_end);
      frame_done <= frame_end;
      busy       <= !idle;
    end
  end
endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: directed checks of timing, patterns, stop/restart, reset and wrap
module tb_video_pattern_source;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, en_b = 1'b0;
  logic [1:0] mode = '0, mode_b = '0;
  logic [15:0] const_val = '0, const_b = '0;
  logic vsync_a, href_a, clken_a, frame_done_a, busy_a;
  logic [7:0] data_a;
  logic [15:0] pix_x_a, pix_y_a;
  logic [1:0] frame_cnt_a;
  logic vsync_b, href_b, clken_b, frame_done_b, busy_b;
  logic [15:0] data_b, pix_x_b, pix_y_b;
  logic [7:0] frame_cnt_b;
  int n_tests = 0, n_fail = 0;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  video_pattern_source #(
    .IMG_HDISP(32), .IMG_VDISP(4), .H_BLANK(8), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .VSYNC_VALID(1'b1), .DATA_W(8), .FRAME_CNT_W(2)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .const_val(const_val), .vsync(vsync_a),
    .href(href_a), .data(data_a), .clken(clken_a), .pix_x(pix_x_a), .pix_y(pix_y_a),
    .frame_cnt(frame_cnt_a), .frame_done(frame_done_a), .busy(busy_a)
  );

  video_pattern_source #(
    .IMG_HDISP(32), .IMG_VDISP(16), .H_BLANK(8), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1),
    .VSYNC_VALID(1'b1), .DATA_W(16), .FRAME_CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .const_val(const_b), .vsync(vsync_b),
    .href(href_b), .data(data_b), .clken(clken_b), .pix_x(pix_x_b), .pix_y(pix_y_b),
    .frame_cnt(frame_cnt_b), .frame_done(frame_done_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check("rst_vsync", vsync_a, 0);
    check("rst_href", href_a, 0);
    check("rst_data", data_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_frame_cnt", frame_cnt_a, 0);
    check("rst_frame_done", frame_done_a, 0);
    check("rst_vsync_b", vsync_b, 0);
    rst = 1'b0;
    en = 1'b1;
    mode = 2'd0;
    step(1);
    check("start_no_vsync", vsync_a, 0);
    check("start_not_busy", busy_a, 0);
    step(1);
    check("first_vsync", vsync_a, 1);
    check("first_busy", busy_a, 1);
    step(71);
    check("vsync_line_end", vsync_a, 1);
    step(1);
    check("vsync_drop", vsync_a, 0);
    step(72);
    check("act0_href", href_a, 1);
    check("act0_clken", clken_a, 1);
    check("act0_data", data_a, 0);
    check("act0_pix_y", pix_y_a, 0);
    step(72);
    for (int i = 0; i < 64; i++) begin
      check("ramp_href", href_a, 1);
      check("ramp_data", data_a, (i % 2) ? i / 2 + 1 : 0);
      check("ramp_pix_x", pix_x_a, i / 2);
      step(1);
    end
    check("blank_href", href_a, 0);
    check("blank_clken", clken_a, 0);
    check("blank_data", data_a, 0);
    check("blank_pix_x", pix_x_a, 0);
    check("blank_pix_y", pix_y_a, 1);
    step(222);
    check("done_early", frame_done_a, 0);
    step(1);
    check("done_f0", frame_done_a, 1);
    check("cnt_f0", frame_cnt_a, 1);
    step(1);
    check("done_pulse", frame_done_a, 0);
    check("f1_vsync", vsync_a, 1);
    step(144);
    check("f1_hi", data_a, 0);
    step(1);
    check("f1_lo", data_a, 1);
    step(358);
    check("done_f1", frame_done_a, 1);
    check("cnt_f1", frame_cnt_a, 2);
    step(101);
    mode = 2'd3;
    const_val = 16'hA55A;
    step(44);
    check("f2_hi", data_a, 0);
    step(1);
    check("f2_mode_ignored", data_a, 2);
    step(55);
    en = 1'b0;
    step(303);
    check("done_f2", frame_done_a, 1);
    check("cnt_f2", frame_cnt_a, 3);
    check("busy_vfront", busy_a, 1);
    step(1);
    check("stop_busy", busy_a, 0);
    check("stop_vsync", vsync_a, 0);
    check("stop_cnt", frame_cnt_a, 3);
    step(100);
    check("idle_busy", busy_a, 0);
    check("idle_vsync", vsync_a, 0);
    check("idle_href", href_a, 0);
    en = 1'b1;
    step(1);
    check("restart_wait", vsync_a, 0);
    step(1);
    check("restart_vsync", vsync_a, 1);
    step(10);
    mode = 2'd0;
    step(134);
    check("const_b0", data_a, 8'hA5);
    step(1);
    check("const_b1", data_a, 8'h5A);
    step(1);
    check("const_b2", data_a, 8'hA5);
    step(357);
    check("wrap_done", frame_done_a, 1);
    check("wrap_cnt", frame_cnt_a, 0);
    step(217);
    check("f4_hi", data_a, 0);
    step(1);
    check("f4_lo", data_a, 1);
    check("f4_pix_y", pix_y_a, 1);
    step(2);
    check("f4_x1", data_a, 2);
    check("f4_pix_x", pix_x_a, 1);
    rst = 1'b1;
    #1;
    check("arst_href", href_a, 0);
    check("arst_clken", clken_a, 0);
    check("arst_data", data_a, 0);
    check("arst_pix_x", pix_x_a, 0);
    check("arst_pix_y", pix_y_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_vsync", vsync_a, 0);
    en = 1'b0;
    step(2);
    rst = 1'b0;
    mode_b = 2'd2;
    en_b = 1'b1;
    step(1);
    check("b_wait", vsync_b, 0);
    step(1);
    check("b_vsync", vsync_b, 1);
    step(80);
    for (int i = 0; i < 32; i++) begin
      check("bars_href", href_b, 1);
      check("bars_data", data_b, bars[i / 4]);
      check("bars_pix_x", pix_x_b, i);
      step(1);
    end
    check("bars_blank", href_b, 0);
    check("bars_blank_data", data_b, 0);
    mode_b = 2'd1;
    step(16);
    check("bars_line1", data_b, 16'h07FF);
    check("bars_pix_y", pix_y_b, 1);
    step(712);
    check("b_cnt", frame_cnt_b, 1);
    for (int i = 0; i < 16; i++) begin
      check("chk_line0", data_b, i < 8 ? 16'h0000 : 16'hFFFF);
      step(1);
    end
    step(304);
    check("chk_pix_y", pix_y_b, 8);
    for (int i = 0; i < 16; i++) begin
      check("chk_line8", data_b, i < 8 ? 16'hFFFF : 16'h0000);
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
